pipe_cla_adder: RTL and testbench

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/pipe_cla_adder.sv | 156 +++++++++++++++
 tb/tb_pipe_cla_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_cla_adder.sv
// Segmented, pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Each stage resolves one SEG-bit slice; a final register computes the flags.
module pipe_cla_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSEG = WIDTH / SEG;

  if (SEG < 1 || WIDTH < 2 || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("pipe_cla_adder: WIDTH must be >= 2 and a multiple of SEG >= 1");
  end

  typedef logic [WIDTH-1:0] word_t;

  // Flat lookahead over one segment: every carry is expanded from g/p and the segment carry-in.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           ci);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           c_n;
    logic           pp;
    g   = a & b;
    p   = a ^ b;
    c   = '0;
    c_n = 1'b0;
    pp  = 1'b0;
    c[0] = ci;
    for (int i = 0; i < int'(SEG); i++) begin
      c_n = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_n = c_n | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = c_n | (pp & ci);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic            stall_c;
  logic [NSEG-1:0] st_valid_q, st_valid_d;
  logic [NSEG-1:0] st_carry_q, st_carry_d;
  word_t           st_a_q   [NSEG];
  word_t           st_a_d   [NSEG];
  word_t           st_b_q   [NSEG];
  word_t           st_b_d   [NSEG];
  word_t           st_sum_q [NSEG];
  word_t           st_sum_d [NSEG];

  logic  out_valid_q, out_valid_d;
  word_t sum_q, sum_d;
  logic  cout_q, cout_d;
  logic  ovf_q, ovf_d;
  logic  zero_q, zero_d;

  assign stall_c  = out_valid_q & ~out_ready;
  assign in_ready = ~stall_c;

  for (genvar k = 0; k < int'(NSEG); k++) begin : g_stage
    localparam word_t SEG_MASK = word_t'({SEG{1'b1}}) << (k * SEG);

    logic         v_c;
    logic         ci_c;
    word_t        a_c;
    word_t        b_c;
    word_t        s_c;
    logic [SEG:0] r_c;

    // Stage 0 takes the effective operands; later stages take their predecessor's register.
    if (k == 0) begin : g_src
      assign v_c  = in_valid;
      assign a_c  = ain;
      assign b_c  = op ? ~bin : bin;
      assign ci_c = op | cin;
      assign s_c  = '0;
    end else begin : g_src
      assign v_c  = st_valid_q[k-1];
      assign a_c  = st_a_q[k-1];
      assign b_c  = st_b_q[k-1];
      assign ci_c = st_carry_q[k-1];
      assign s_c  = st_sum_q[k-1];
    end

    assign r_c           = cla_seg(a_c[k*SEG +: SEG], b_c[k*SEG +: SEG], ci_c);
    assign st_valid_d[k] = v_c;
    assign st_carry_d[k] = r_c[SEG];
    assign st_a_d[k]     = a_c;
    assign st_b_d[k]     = b_c;
    assign st_sum_d[k]   = (s_c & ~SEG_MASK) | (word_t'(r_c[SEG-1:0]) << (k * SEG));
  end

  // Flags are derived from the fully resolved sum leaving the last segment stage.
  always_comb begin
    out_valid_d = st_valid_q[NSEG-1];
    sum_d       = st_sum_q[NSEG-1];
    cout_d      = st_carry_q[NSEG-1];
    ovf_d       = (st_a_q[NSEG-1][WIDTH-1] == st_b_q[NSEG-1][WIDTH-1]) &&
                  (st_sum_q[NSEG-1][WIDTH-1] != st_a_q[NSEG-1][WIDTH-1]);
    zero_d      = (st_sum_q[NSEG-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_q  <= '0;
      st_carry_q  <= '0;
      for (int k = 0; k < int'(NSEG); k++) begin
        st_a_q[k]   <= '0;
        st_b_q[k]   <= '0;
        st_sum_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (!stall_c) begin
      st_valid_q  <= st_valid_d;
      st_carry_q  <= st_carry_d;
      for (int k = 0; k < int'(NSEG); k++) begin
        st_a_q[k]   <= st_a_d[k];
        st_b_q[k]   <= st_b_d[k];
        st_sum_q[k] <= st_sum_d[k];
      end
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Bench for pipe_cla_adder: arithmetic reference model with a per-cycle scoreboard,
// plus directed vectors with literal expectations.
module tb_pipe_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] ain;
  logic [31:0] bin;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  pipe_cla_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ain(ain), .bin(bin), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_pop  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic on wide integers.
  function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      r;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o) begin
      u   = {1'b0, a} - {1'b0, b};
      e.c = (a >= b);
      r   = sa - sb;
    end else begin
      u   = 33'(a) + 33'(b) + 33'(ci);
      e.c = u[32];
      r   = sa + sb + longint'(ci);
    end
    e.s = u[31:0];
    e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.z = (e.s == 32'd0);
    return e;
  endfunction

  // Scoreboard: sampled mid-cycle, reflecting what the next rising edge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_flags", {27'd0, sum, cout, ovf, zero}, 64'd0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 64'(sum), 64'hDEAD_0000_0000);
        end else begin
          chk("sum", 64'(sum), 64'(q[0].s));
          chk("cout_ovf_zero", {61'd0, cout, ovf, zero}, {61'd0, q[0].c, q[0].o, q[0].z});
          if (out_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(op, ain, bin, cin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single op, checked against literals including the exact latency.
  task automatic run_one(input string name, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input logic ci, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
    int cnt;
    in_valid = 1'b1; op = o; ain = a; bin = b; cin = ci;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({name, "_latency"}, 64'(cnt), 64'd4);
    chk({name, "_sum"}, 64'(sum), 64'(es));
    chk({name, "_flags"}, {61'd0, cout, ovf, zero}, {61'd0, ec, eo, ez});
    tick();
  endtask

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic acc;
    in_valid = 1'b1; op = o; ain = a; bin = b; cin = ci;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    if (!acc) chk("issue_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 60) begin
      tick();
      t++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; ain = '0; bin = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    run_one("wrap_add", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("sub_neg",  1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("add_ovf",  1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub_ovf",  1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("seg_cry",  1'b0, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_one("sub_cin",  1'b1, 32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("long_cry", 1'b0, 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0);

    // Eight back-to-back ops with a three-cycle stall once the pipe has filled.
    p0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue(i[0], 32'h1111_1111 * i, 32'h0F0F_0F0F ^ 32'(i), i[1]);
      end
      begin
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
          tick();
          t++;
        end
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_valid", 64'(out_valid), 64'd1);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("b2b_count", 64'(n_pop - p0), 64'd8);

    // Irregular consumer pattern.
    p0 = n_pop;
    fork
      begin
        for (int i = 0; i < 16; i++)
          issue(i[1], 32'h8765_4321 + 32'(i * 32'h0101_0101), 32'hFEDC_BA98 >> i, i[0]);
      end
      begin
        for (int t = 0; t < 60; t++) begin
          out_ready = ((t % 3) != 1) && ((t % 7) != 3);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("pattern_count", 64'(n_pop - p0), 64'd16);

    // Reset with three ops in flight.
    issue(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0);
    issue(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0);
    issue(1'b1, 32'h0000_0009, 32'h0000_0004, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      chk("post_reset_idle", 64'(out_valid), 64'd0);
      tick();
    end
    run_one("after_rst", 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
